// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, FSM states,
// the NOP substituted on fetch errors, and the 32-bit word select helper.
package ifu_fetch_pkg;

  localparam int          IFU_ADDR_W   = 64;
  localparam int          IFU_BUS_W    = 64;
  localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_DROP = 3'd4
  } fetch_state_e;

  // Each response beat carries two instructions; PC bit 2 picks the upper one.
  function automatic logic [31:0] sel_word(input logic [IFU_BUS_W-1:0] data,
                                           input logic                 upper);
    return upper ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/ifu_inst_buf.sv
// One-entry output register holding the fetched instruction for decode.
// load captures a new entry, clear empties it on consumption, and kill
// hides the entry combinationally in the same cycle a redirect discards it.
module ifu_inst_buf
  import ifu_fetch_pkg::*;
#(
  parameter int ADDR_W = IFU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [31:0]       load_inst,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              load_err,
  input  logic              clear,
  input  logic              kill,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              fetch_err,
  output logic              ivalid
);

  logic valid_q;

  // Entry register: load has priority, clear only drops the valid bit so the
  // payload stays stable until the next load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ir        <= '0;
      ir_pc     <= '0;
      fetch_err <= 1'b0;
    end else if (load) begin
      valid_q   <= 1'b1;
      ir        <= load_inst;
      ir_pc     <= load_pc;
      fetch_err <= load_err;
    end else if (clear) begin
      valid_q   <= 1'b0;
    end
  end

  assign ivalid = valid_q & ~kill;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding request on the imem port, word
// select from the 64-bit beat, one-entry hold buffer towards decode, and
// redirect handling that discards in-flight or buffered instructions.
//
//   state | meaning
//   BOOT  | first cycle after reset, capture the boot PC
//   REQ   | request for pend_pc presented, waiting for ready
//   WAIT  | request accepted, waiting for the response beat
//   HOLD  | instruction buffered, waiting for decode to take it
//   DROP  | redirected while a request was in flight, swallow its response
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int          ADDR_W   = IFU_ADDR_W,
  parameter int          BUS_W    = IFU_BUS_W,
  parameter logic [31:0] NOP_INST = IFU_NOP_INST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_en,
  input  logic              flush,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ivalid,
  output logic              fetch_err,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [BUS_W-1:0]  imem_rsp_data,
  input  logic              imem_rsp_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

  logic              redirect;
  logic              misaligned;
  logic              buf_load;
  logic [31:0]       buf_inst;
  logic              buf_err;
  logic              buf_clear;
  logic              buf_kill;

  assign redirect   = flush & fetch_en;
  assign misaligned = |pend_pc_q[1:0];

  // State and pending-PC registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_BOOT;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Next-state, pending-PC update, request strobe and buffer controls.
  always_comb begin
    state_d        = state_q;
    pend_pc_d      = pend_pc_q;
    imem_req_valid = 1'b0;
    buf_load       = 1'b0;
    buf_inst       = NOP_INST;
    buf_err        = 1'b0;
    buf_clear      = 1'b0;
    buf_kill       = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pend_pc_d = fetch_addr;
        state_d   = ST_REQ;
      end

      ST_REQ: begin
        if (misaligned) begin
          // A redirect supersedes the misaligned fetch before it is reported.
          if (redirect) begin
            pend_pc_d = fetch_addr;
          end else begin
            buf_load = 1'b1;
            buf_err  = 1'b1;
            state_d  = ST_HOLD;
          end
        end else begin
          imem_req_valid = 1'b1;
          if (redirect) begin
            // The old address may still be accepted this cycle; its response
            // then has to be swallowed.
            pend_pc_d = fetch_addr;
            if (imem_req_ready) state_d = ST_DROP;
          end else if (imem_req_ready) begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (redirect) begin
          pend_pc_d = fetch_addr;
          state_d   = imem_rsp_valid ? ST_REQ : ST_DROP;
        end else if (imem_rsp_valid) begin
          buf_load = 1'b1;
          buf_err  = imem_rsp_err;
          buf_inst = imem_rsp_err ? NOP_INST
                                  : sel_word(imem_rsp_data[63:0], pend_pc_q[2]);
          state_d  = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (fetch_en) begin
          pend_pc_d = fetch_addr;
          buf_clear = 1'b1;
          buf_kill  = flush;
          state_d   = ST_REQ;
        end
      end

      ST_DROP: begin
        if (redirect) pend_pc_d = fetch_addr;
        if (imem_rsp_valid) state_d = ST_REQ;
      end

      default: state_d = ST_BOOT;
    endcase
  end

  assign imem_req_addr = {pend_pc_q[ADDR_W-1:3], 3'b000};

  ifu_inst_buf #(
    .ADDR_W(ADDR_W)
  ) u_inst_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .load_inst (buf_inst),
    .load_pc   (pend_pc_q),
    .load_err  (buf_err),
    .clear     (buf_clear),
    .kill      (buf_kill),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .fetch_err (fetch_err),
    .ivalid    (ivalid)
  );

  // A response is only legal while a request is outstanding.
  a_rsp_only_when_outstanding : assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (state_q == ST_WAIT || state_q == ST_DROP)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a word-level memory, a PC-tracking model of
// what decode must see, and literal expectations for the key scenarios.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] fetch_addr;
  logic        fetch_en;
  logic        flush;
  logic [31:0] ir;
  logic [63:0] ir_pc;
  logic        ivalid;
  logic        fetch_err;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [63:0] imem_rsp_data;
  logic        imem_rsp_err;

  int vectors     = 0;
  int miscompares = 0;

  ifu_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_addr     (fetch_addr),
    .fetch_en       (fetch_en),
    .flush          (flush),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ivalid         (ivalid),
    .fetch_err      (fetch_err),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err)
  );

  always #5 clk = ~clk;

  // Memory contents by 32-bit word address.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0010_0093;
    if (a == 64'h8000_0004) return 32'h0020_0113;
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // Fetch errors: misaligned PC, or the 0xE... region faults on the bus.
  function automatic logic exp_err(input logic [63:0] pc);
    return (pc[1:0] != 2'b00) || (pc[31:28] == 4'hE);
  endfunction

  function automatic logic [31:0] exp_ir(input logic [63:0] pc);
    if (exp_err(pc)) return 32'h0000_0013;
    return word_at({pc[63:2], 2'b00});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event not seen within cycle budget at %0t", name, $time);
  endtask

  // Memory: one response per accepted request, rsp_delay extra cycles late.
  int          rsp_delay = 0;
  int          acc_count = 0;
  logic [63:0] last_acc_addr = '0;

  initial begin
    logic        s_rst, s_acc, s_rsp, busy;
    logic [63:0] s_addr, q_addr;
    int          cnt;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    busy = 1'b0;
    cnt  = 0;
    q_addr = '0;
    forever begin
      @(negedge clk);
      s_rst  = rst_n;
      s_acc  = rst_n && imem_req_valid && imem_req_ready;
      s_addr = imem_req_addr;
      s_rsp  = imem_rsp_valid;
      @(posedge clk);
      #1;
      if (!s_rst) begin
        busy = 1'b0;
        imem_rsp_valid = 1'b0;
      end else begin
        if (s_rsp) begin
          imem_rsp_valid = 1'b0;
          busy = 1'b0;
        end
        if (s_acc) begin
          busy = 1'b1;
          cnt = rsp_delay;
          q_addr = s_addr;
          last_acc_addr = s_addr;
          acc_count++;
        end
        if (busy && !imem_rsp_valid) begin
          if (cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = {word_at(q_addr + 64'd4), word_at(q_addr)};
            imem_rsp_err   = (q_addr[31:28] == 4'hE);
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Model: the instruction decode must see is the one at the last PC it
  // asked for (boot capture, consumption or redirect).
  logic [63:0] exp_pc = '0;
  logic        boot_pending = 1'b1;

  always @(negedge clk) begin
    if (rst_n && ivalid) begin
      chk("model_ir_pc", ir_pc, exp_pc);
      chk("model_ir", {32'd0, ir}, {32'd0, exp_ir(exp_pc)});
      chk("model_fetch_err", {63'd0, fetch_err}, {63'd0, exp_err(exp_pc)});
    end
    if (rst_n && imem_req_valid)
      chk("model_req_addr", imem_req_addr, {exp_pc[63:3], 3'b000});
    if (rst_n && !boot_pending && exp_pc[1:0] != 2'b00)
      chk("model_no_req_misaligned", {63'd0, imem_req_valid}, 64'd0);
    if (!rst_n)
      boot_pending = 1'b1;
    else if (boot_pending) begin
      exp_pc = fetch_addr;
      boot_pending = 1'b0;
    end else if (fetch_en && (ivalid || flush))
      exp_pc = fetch_addr;
  end

  task automatic wait_ivalid(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (ivalid) return;
    end
    timeout("wait_ivalid");
  endtask

  task automatic wait_acc();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) return;
    end
    timeout("wait_accept");
  endtask

  task automatic consume(input logic [63:0] addr, input logic fl);
    @(posedge clk);
    #1;
    fetch_addr = addr;
    fetch_en   = 1'b1;
    flush      = fl;
    @(posedge clk);
    #1;
    fetch_en   = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int c0;
    rst_n          = 1'b0;
    fetch_addr     = 64'h8000_0000;
    fetch_en       = 1'b0;
    flush          = 1'b0;
    imem_req_ready = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ivalid", {63'd0, ivalid}, 64'd0);
    chk("rst_fetch_err", {63'd0, fetch_err}, 64'd0);
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_ir", {32'd0, ir}, 64'd0);
    chk("rst_ir_pc", ir_pc, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Boot fetch
    wait_ivalid(lat);
    chk("boot_ir", {32'd0, ir}, 64'h0010_0093);
    chk("boot_ir_pc", ir_pc, 64'h8000_0000);
    chk("boot_req_addr", last_acc_addr, 64'h8000_0000);

    // Upper word select and accept-to-valid latency
    consume(64'h8000_0004, 1'b0);
    wait_ivalid(lat);
    chk("sel_latency", lat, 3);
    chk("sel_ir", {32'd0, ir}, 64'h0020_0113);
    chk("sel_req_addr", last_acc_addr, 64'h8000_0000);

    // Backpressure: buffer stable, no new request
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ivalid", {63'd0, ivalid}, 64'd1);
      chk("bp_ir", {32'd0, ir}, 64'h0020_0113);
      chk("bp_req_valid", {63'd0, imem_req_valid}, 64'd0);
    end

    // Redirect while WAIT with a slow response
    rsp_delay = 4;
    consume(64'h8000_0008, 1'b0);
    wait_acc();
    @(posedge clk);
    #1;
    fetch_addr = 64'h8000_0100;
    fetch_en   = 1'b1;
    flush      = 1'b1;
    @(posedge clk);
    #1;
    fetch_en   = 1'b0;
    flush      = 1'b0;
    wait_ivalid(lat);
    chk("wait_flush_ir_pc", ir_pc, 64'h8000_0100);
    chk("wait_flush_ir", {32'd0, ir}, 64'h9357_9ADF);
    rsp_delay = 0;

    // Redirect while HOLD: valid dropped in the same cycle
    @(posedge clk);
    #1;
    fetch_addr = 64'h8000_0200;
    fetch_en   = 1'b1;
    flush      = 1'b1;
    @(negedge clk);
    chk("hold_flush_kill", {63'd0, ivalid}, 64'd0);
    @(posedge clk);
    #1;
    fetch_en   = 1'b0;
    flush      = 1'b0;
    wait_ivalid(lat);
    chk("hold_flush_ir_pc", ir_pc, 64'h8000_0200);

    // Redirect while REQ is stalled by ready
    imem_req_ready = 1'b0;
    consume(64'h8000_0300, 1'b0);
    @(negedge clk);
    chk("req_stall_valid", {63'd0, imem_req_valid}, 64'd1);
    @(posedge clk);
    #1;
    fetch_addr = 64'h8000_0400;
    fetch_en   = 1'b1;
    flush      = 1'b1;
    @(posedge clk);
    #1;
    fetch_en   = 1'b0;
    flush      = 1'b0;
    @(negedge clk);
    chk("req_flush_addr", imem_req_addr, 64'h8000_0400);
    @(posedge clk);
    #1 imem_req_ready = 1'b1;
    wait_ivalid(lat);
    chk("req_flush_ir_pc", ir_pc, 64'h8000_0400);

    // Bus error
    consume(64'hE000_0010, 1'b0);
    wait_ivalid(lat);
    chk("buserr_ir", {32'd0, ir}, 64'h0000_0013);
    chk("buserr_flag", {63'd0, fetch_err}, 64'd1);

    // Misaligned PC: no request at all
    c0 = acc_count;
    consume(64'h8000_0002, 1'b0);
    wait_ivalid(lat);
    chk("misalign_no_req", acc_count, c0);
    chk("misalign_ir", {32'd0, ir}, 64'h0000_0013);
    chk("misalign_flag", {63'd0, fetch_err}, 64'd1);
    chk("misalign_ir_pc", ir_pc, 64'h8000_0002);

    // Reset while WAIT
    rsp_delay = 4;
    consume(64'h8000_0500, 1'b0);
    wait_acc();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstwait_ivalid", {63'd0, ivalid}, 64'd0);
    chk("rstwait_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rstwait_ir", {32'd0, ir}, 64'd0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    rsp_delay  = 0;
    fetch_addr = 64'h8000_0600;
    wait_acc();
    chk("rstwait_fresh_req", imem_req_addr, 64'h8000_0600);
    wait_ivalid(lat);
    chk("rstwait_ir_pc", ir_pc, 64'h8000_0600);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
